ce_grad_unit: RTL and testbench

- Backward-pass entry point of the CNN: cross-entropy loss-gradient generator.
- Takes one softmax probability vector plus the integer class label, and produces the per-class output error grad[i] = p[i] - onehot(label)[i] that drives the fully connected layer's output-error input.
- Also reports the argmax prediction and a correct flag.
- Processes one class per cycle using valid/ready handshakes on both sides.

---
 rtl/cnn_pkg.sv | 33 +++
 rtl/ce_grad_unit_argmax.sv | 39 +++
 rtl/ce_grad_unit.sv | 189 ++++++++++++++++++
 tb/tb_ce_grad_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN fixed-point constants, state type and saturation helper.
// Used by the loss-gradient stage and the argmax tracker.
package cnn_pkg;

  localparam int WIDTH     = 16;
  localparam int FRAC_BITS = 8;
  localparam int ONE       = 1 << FRAC_BITS;

  typedef enum logic [1:0] {
    CE_IDLE    = 2'd0,
    CE_COMPUTE = 2'd1,
    CE_DONE    = 2'd2
  } ce_state_t;

  // Clamp a sign-extended value into the signed range of a w-bit word.
  function automatic logic signed [32:0] sat_w(
    input logic signed [32:0] v,
    input int                 w
  );
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    hi = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (w - 1));
    if (v > hi) begin
      sat_w = hi;
    end else if (v < lo) begin
      sat_w = lo;
    end else begin
      sat_w = v;
    end
  endfunction

endpackage

// File: rtl/ce_grad_unit_argmax.sv
// Running argmax: init seeds the max, each step compares one element.
// Strict compare keeps the lowest index on ties.
module argmax_tracker #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    init_i,
  input  logic signed [WIDTH-1:0] init_val_i,
  input  logic                    step_i,
  input  logic signed [WIDTH-1:0] val_i,
  input  logic [IDX_W-1:0]        idx_i,
  output logic [IDX_W-1:0]        res_idx_o
);
  import cnn_pkg::*;

  logic signed [WIDTH-1:0] best_val_q;
  logic [IDX_W-1:0]        best_idx_q;
  logic                    gt;

  assign gt        = step_i && (val_i > best_val_q);
  assign res_idx_o = gt ? idx_i : best_idx_q;

  // hold the best value/index seen so far in this sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_val_q <= '0;
      best_idx_q <= '0;
    end else if (init_i) begin
      best_val_q <= init_val_i;
      best_idx_q <= '0;
    end else if (gt) begin
      best_val_q <= val_i;
      best_idx_q <= idx_i;
    end
  end

endmodule

// File: rtl/ce_grad_unit.sv
// Cross-entropy gradient generator: grad = p - onehot(label), one class/cycle.
// Statistics counters are built only when CE_GRAD_STATS_EN is defined.
module ce_grad_unit #(
  parameter int WIDTH       = cnn_pkg::WIDTH,
  parameter int FRAC_BITS   = cnn_pkg::FRAC_BITS,
  parameter int NUM_CLASSES = 10,
  parameter int LABEL_W     = $clog2(NUM_CLASSES) + 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [NUM_CLASSES-1:0][WIDTH-1:0]   probs,
  input  logic [LABEL_W-1:0]                  label,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [NUM_CLASSES-1:0][WIDTH-1:0]   grad,
  output logic [LABEL_W-1:0]                  pred,
  output logic                                correct,
  output logic                                label_err,
  input  logic                                clear_stats,
  output logic [31:0]                         sample_count,
  output logic [31:0]                         correct_count
);
  import cnn_pkg::*;

  localparam int IDX_W = $clog2(NUM_CLASSES);

  localparam logic [1:0] S_IDLE    = CE_IDLE;
  localparam logic [1:0] S_COMPUTE = CE_COMPUTE;
  localparam logic [1:0] S_DONE    = CE_DONE;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);
  localparam logic [WIDTH:0]   ONE_X    =
    {{WIDTH{1'b0}}, 1'b1} << FRAC_BITS;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [NUM_CLASSES-1:0][WIDTH-1:0] probs_q;
  logic [NUM_CLASSES-1:0][WIDTH-1:0] grad_q;
  logic [LABEL_W-1:0]                label_q;
  logic [LABEL_W-1:0]                pred_q;
  logic                              correct_q;
  logic                              label_err_q;
  logic                              out_valid_q;

  logic                    accept;
  logic                    computing;
  logic                    last;
  logic                    out_fire;
  logic signed [WIDTH-1:0] p_cur;
  logic                    hit;
  logic signed [WIDTH:0]   diff;
  logic signed [32:0]      sat_full;
  logic [WIDTH-1:0]        g_cur;
  logic                    unused_sat;
  logic [IDX_W-1:0]        res_idx;

  assign in_ready  = reset && (state_q == S_IDLE);
  assign accept    = in_valid && in_ready;
  assign computing = (state_q == S_COMPUTE);
  assign last      = computing && (idx_q == LAST_IDX);
  assign out_fire  = out_valid_q && out_ready;

  assign p_cur      = probs_q[idx_q];
  assign hit        = !label_err_q && (LABEL_W'(idx_q) == label_q);
  assign diff       = {p_cur[WIDTH-1], p_cur} - (hit ? ONE_X : '0);
  assign sat_full   = sat_w(33'(diff), WIDTH);
  assign g_cur      = sat_full[WIDTH-1:0];
  assign unused_sat = ^sat_full[32:WIDTH];

  assign out_valid = out_valid_q;
  assign grad      = grad_q;
  assign pred      = pred_q;
  assign correct   = correct_q;
  assign label_err = label_err_q;

  argmax_tracker #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_argmax (
    .clk        (clk),
    .rst_n      (reset),
    .init_i     (accept),
    .init_val_i (probs[0]),
    .step_i     (computing),
    .val_i      (p_cur),
    .idx_i      (idx_q),
    .res_idx_o  (res_idx)
  );

  // next state and class index
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_COMPUTE;
          idx_d   = '0;
        end
      end
      S_COMPUTE: begin
        if (last) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // control registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // sample capture, per-class gradient and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      probs_q     <= '0;
      label_q     <= '0;
      grad_q      <= '0;
      pred_q      <= '0;
      correct_q   <= 1'b0;
      label_err_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        probs_q     <= probs;
        label_q     <= label;
        label_err_q <= (label >= LABEL_W'(NUM_CLASSES));
      end
      if (computing) begin
        grad_q[idx_q] <= g_cur;
      end
      if (last) begin
        pred_q      <= LABEL_W'(res_idx);
        correct_q   <= !label_err_q &&
                       (LABEL_W'(res_idx) == label_q);
        out_valid_q <= 1'b1;
      end else if (out_fire) begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef CE_GRAD_STATS_EN
  logic [31:0] samp_q;
  logic [31:0] corr_q;

  // completed-sample statistics; clear beats a same-cycle handshake
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      samp_q <= '0;
      corr_q <= '0;
    end else if (clear_stats) begin
      samp_q <= '0;
      corr_q <= '0;
    end else if (out_fire) begin
      samp_q <= samp_q + 32'd1;
      corr_q <= corr_q + {31'd0, correct_q};
    end
  end

  assign sample_count  = samp_q;
  assign correct_count = corr_q;
`else
  logic unused_clr;

  assign unused_clr    = clear_stats;
  assign sample_count  = '0;
  assign correct_count = '0;
`endif

endmodule

// File: tb/tb_ce_grad_unit.sv
// Directed + random bench for ce_grad_unit.
// Expected results come from a plain-arithmetic loss-gradient model.
module tb_ce_grad_unit;

  localparam int NC = 10;
  localparam int W  = 16;
  localparam int LW = 5;

`ifdef CE_GRAD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [NC-1:0][W-1:0] probs = '0;
  logic [LW-1:0]        label = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [NC-1:0][W-1:0] grad;
  logic [LW-1:0]        pred;
  logic                 correct;
  logic                 label_err;
  logic                 clear_stats = 1'b0;
  logic [31:0]          sample_count;
  logic [31:0]          correct_count;

  int n_chk  = 0;
  int n_fail = 0;

  int                   pm [NC];
  int                   lbl;
  logic [NC-1:0][W-1:0] exp_grad;
  int                   exp_pred;
  bit                   exp_corr;
  bit                   exp_lerr;
  int unsigned          m_s = 0;
  int unsigned          m_c = 0;

  always #5 clk = ~clk;

  ce_grad_unit dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .probs         (probs),
    .label         (label),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .grad          (grad),
    .pred          (pred),
    .correct       (correct),
    .label_err     (label_err),
    .clear_stats   (clear_stats),
    .sample_count  (sample_count),
    .correct_count (correct_count)
  );

  task automatic check(input string tag,
                       input logic [NC*W-1:0] obs,
                       input logic [NC*W-1:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic compute_model();
    int best;
    int v;
    best     = pm[0];
    exp_pred = 0;
    for (int i = 0; i < NC; i++) begin
      v = pm[i] - ((lbl == i) ? 256 : 0);
      if (v > 32767)  v = 32767;
      if (v < -32768) v = -32768;
      exp_grad[i] = W'(v);
      if (pm[i] > best) begin
        best     = pm[i];
        exp_pred = i;
      end
    end
    exp_lerr = (lbl >= NC);
    exp_corr = !exp_lerr && (exp_pred == lbl);
  endtask

  task automatic drive_input();
    int n;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_idle", in_ready, 1);
    for (int i = 0; i < NC; i++) probs[i] = W'(pm[i]);
    label    = lbl[LW-1:0];
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("in_ready_busy", in_ready, 0);
  endtask

  task automatic run_sample(input int hold, input bit clr);
    int n;
    compute_model();
    drive_input();
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, NC);
    for (int c = 0; c < hold; c++) begin
      check("bp_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_grad", grad, exp_grad);
      check("bp_pred", pred, exp_pred);
      @(negedge clk);
    end
    check("grad", grad, exp_grad);
    check("pred", pred, exp_pred);
    check("correct", correct, exp_corr);
    check("label_err", label_err, exp_lerr);
    out_ready   = 1'b1;
    clear_stats = clr;
    @(negedge clk);
    out_ready   = 1'b0;
    clear_stats = 1'b0;
    if (clr) begin
      m_s = 0;
      m_c = 0;
    end else begin
      m_s++;
      m_c += exp_corr;
    end
    check("out_valid_drop", out_valid, 0);
    check("in_ready_back", in_ready, 1);
    check("sample_count", sample_count, STATS ? m_s : 0);
    check("correct_count", correct_count, STATS ? m_c : 0);
    check("grad_retained", grad, exp_grad);
  endtask

  initial begin
    #3;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_grad", grad, 0);
    check("rst_pred", pred, 0);
    check("rst_counts", {sample_count, correct_count}, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rel_in_ready", in_ready, 1);
    check("rel_flags", {correct, label_err}, 0);

    // exact one-hot hit
    for (int i = 0; i < NC; i++) pm[i] = 0;
    pm[3] = 256;
    lbl   = 3;
    run_sample(0, 1'b0);

    // wrong prediction
    for (int i = 0; i < NC; i++) pm[i] = 25;
    pm[7] = 31;
    lbl   = 2;
    run_sample(0, 1'b0);

    // tie resolves low, with backpressure
    for (int i = 0; i < NC; i++) pm[i] = 25;
    lbl = 9;
    run_sample(5, 1'b0);

    // out-of-range label
    for (int i = 0; i < NC; i++) pm[i] = 10 * i - 20;
    lbl = 12;
    run_sample(1, 1'b0);

    // negative saturation
    for (int i = 0; i < NC; i++) pm[i] = 0;
    pm[0] = -32768;
    lbl   = 0;
    run_sample(0, 1'b0);

    // reset mid-computation
    for (int i = 0; i < NC; i++) pm[i] = 40;
    lbl = 1;
    compute_model();
    drive_input();
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_counts", {sample_count, correct_count}, 0);
    check("mid_rst_grad", grad, 0);
    m_s = 0;
    m_c = 0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_release", in_ready, 1);

    // counting: 3 samples, 2 correct
    for (int i = 0; i < NC; i++) pm[i] = 0;
    pm[5] = 200;
    lbl   = 5;
    run_sample(0, 1'b0);
    lbl   = 4;
    run_sample(0, 1'b0);
    pm[5] = 0;
    pm[8] = 100;
    lbl   = 8;
    run_sample(2, 1'b0);

    // clear coinciding with handshake
    lbl = 8;
    run_sample(0, 1'b1);

    // random samples
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NC; i++) begin
        if (k % 3 == 0)
          pm[i] = int'($urandom_range(0, 65535)) - 32768;
        else
          pm[i] = int'($urandom_range(0, 300));
      end
      lbl = int'($urandom_range(0, 12));
      run_sample(int'($urandom_range(0, 3)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
